cmd_sender: RTL and testbench



---
 rtl/cmd_link_pkg.sv | 25 ++
 rtl/cmd_sender_if.sv | 27 ++
 rtl/cmd_sender_uart_tx.sv | 75 +++++++
 rtl/cmd_sender.sv | 138 +++++++++++++
 tb/tb_cmd_sender.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_link_pkg.sv
// Shared types and frame constants for the 16-bit command link.
// Byte order is fixed by HI_FIRST; the helpers pick the first/second byte on the wire.
package cmd_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP,
    LOW
  } state_t;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam bit   HI_FIRST   = 1'b1;

  function automatic logic [7:0] first_byte(input logic [15:0] word);
    return HI_FIRST ? word[15:8] : word[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] word);
    return HI_FIRST ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/cmd_sender_if.sv
// Issuer-side command/status bundle of the command link transmitter.
// master = command issuer, slave = cmd_sender.
interface cmd_sender_if;

  logic [15:0] cmd;
  logic        snd_cmd;
  logic        TX;
  logic        cmd_snt;
  logic        tx_busy;

  modport master (
    output cmd,
    output snd_cmd,
    input  TX,
    input  cmd_snt,
    input  tx_busy
  );

  modport slave (
    input  cmd,
    input  snd_cmd,
    output TX,
    output cmd_snt,
    output tx_busy
  );

endinterface

// File: rtl/cmd_sender_uart_tx.sv
// 8N1 UART transmitter: baud counter, bit counter and a 10-bit shift register feeding the TX flop.
// tx_done rises for the final clock of the stop bit so the next trmt lands with no idle cycle.
module uart_tx
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam logic [11:0] BAUD_TC   = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 2);
  localparam logic [3:0]  LAST_BIT  = 4'(FRAME_BITS - 1);
  localparam logic [3:0]  ALL_BITS  = 4'(FRAME_BITS);

  logic                  busy_q, busy_d;
  logic [11:0]           baud_cnt_q, baud_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  tx_done_q, tx_done_d;

  always_comb begin
    busy_d     = busy_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_done_d  = tx_done_q;
    if (trmt && !busy_q) begin
      shift_d    = {STOP_BIT, tx_data, START_BIT};
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      busy_d     = 1'b1;
      tx_done_d  = 1'b0;
    end else if (busy_q) begin
      // Stop bit is already on TX; release one clock early so it still lasts BAUD_DIV clocks.
      if (bit_cnt_q == LAST_BIT && baud_cnt_q == BAUD_LAST) begin
        busy_d     = 1'b0;
        tx_done_d  = 1'b1;
        bit_cnt_d  = ALL_BITS;
        baud_cnt_d = '0;
      end else if (baud_cnt_q == BAUD_TC) begin
        baud_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
        shift_d    = {STOP_BIT, shift_q[FRAME_BITS-1:1]};
      end else begin
        baud_cnt_d = baud_cnt_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '1;
      tx_done_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = shift_q[0];
  assign tx_done = tx_done_q;

endmodule

// File: rtl/cmd_sender.sv
// Command link transmitter: sends a 16-bit word as two 8N1 frames, high byte first.
// Define CMD_TX_GAP_EN to insert GAP_BITS idle bit-times between the two frames.
module cmd_sender
  import cmd_link_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int GAP_BITS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  cmd_sender_if.slave  bus
);

  if (BAUD_DIV < 4 || BAUD_DIV > 4095) begin : g_bad_baud
    $error("cmd_sender: BAUD_DIV must be within 4..4095");
  end
  if (GAP_BITS < 1 || GAP_BITS > 15) begin : g_bad_gap
    $error("cmd_sender: GAP_BITS must be within 1..15");
  end

  state_t      state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        cmd_snt_q, cmd_snt_d;
  logic        tx_busy_q, tx_busy_d;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        tx_line;

`ifdef CMD_TX_GAP_EN
  localparam logic [11:0] BAUD_TC  = 12'(BAUD_DIV - 1);
  localparam logic [3:0]  GAP_LAST = 4'(GAP_BITS - 1);

  logic [11:0] gap_baud_q, gap_baud_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cmd_snt_d = cmd_snt_q;
    tx_busy_d = tx_busy_q;
    trmt      = 1'b0;
    tx_data   = second_byte(hold_q);
`ifdef CMD_TX_GAP_EN
    gap_baud_d = gap_baud_q;
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // The first byte comes straight from the bus so its start bit leaves on the accept edge.
        if (bus.snd_cmd) begin
          hold_d    = bus.cmd;
          cmd_snt_d = 1'b0;
          tx_busy_d = 1'b1;
          trmt      = 1'b1;
          tx_data   = first_byte(bus.cmd);
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (tx_done) begin
`ifdef CMD_TX_GAP_EN
          gap_baud_d = '0;
          gap_cnt_d  = '0;
          state_d    = GAP;
`else
          trmt    = 1'b1;
          state_d = LOW;
`endif
        end
      end
      GAP: begin
`ifdef CMD_TX_GAP_EN
        if (gap_baud_q == BAUD_TC) begin
          gap_baud_d = '0;
          if (gap_cnt_q == GAP_LAST) begin
            trmt    = 1'b1;
            state_d = LOW;
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end else begin
          gap_baud_d = gap_baud_q + 12'd1;
        end
`else
        state_d = IDLE;
`endif
      end
      LOW: begin
        if (tx_done) begin
          cmd_snt_d = 1'b1;
          tx_busy_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      cmd_snt_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
`ifdef CMD_TX_GAP_EN
      gap_baud_q <= '0;
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cmd_snt_q  <= cmd_snt_d;
      tx_busy_q  <= tx_busy_d;
`ifdef CMD_TX_GAP_EN
      gap_baud_q <= gap_baud_d;
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (tx_line),
    .tx_done (tx_done)
  );

  assign bus.TX      = tx_line;
  assign bus.cmd_snt = cmd_snt_q;
  assign bus.tx_busy = tx_busy_q;

endmodule

// File: tb/tb_cmd_sender.sv
// Self-checking bench for cmd_sender: TX waveform, status flags and a UART receive model.
// Build with CMD_TX_GAP_EN defined to also exercise the inter-frame gap.
module tb_cmd_sender;

  localparam int B = 16;
  localparam int G = 2;
`ifdef CMD_TX_GAP_EN
  localparam int GAP_CLKS = G * B;
`else
  localparam int GAP_CLKS = 0;
`endif
  localparam int LAT = 20 * B + GAP_CLKS + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int   checks    = 0;
  int   errors    = 0;
  logic model_snt = 1'b0;

  logic       wave[$];
  logic [7:0] rx_bytes[$];

  always #5 clk = ~clk;

  cmd_sender_if bus ();

  cmd_sender #(
    .BAUD_DIV (B),
    .GAP_BITS (G)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected line level t clocks after the high start bit should have begun.
  function automatic logic exp_tx(input logic [15:0] w, input int t);
    logic [7:0] b;
    int         fb;
    int         j;
    if (t < 0) return 1'b1;
    if (t < 10 * B) begin
      b  = w[15:8];
      fb = t;
    end else if (t < 10 * B + GAP_CLKS) begin
      return 1'b1;
    end else if (t < 20 * B + GAP_CLKS) begin
      b  = w[7:0];
      fb = t - 10 * B - GAP_CLKS;
    end else begin
      return 1'b1;
    end
    j = fb / B;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // Receiver model: falling edge, then sample each bit at its centre.
  task automatic decode_wave();
    int         i;
    logic [7:0] d;
    rx_bytes.delete();
    i = 1;
    while (i < wave.size()) begin
      if (wave[i-1] == 1'b1 && wave[i] == 1'b0 && (i + B / 2 + 9 * B) < wave.size()) begin
        for (int k = 0; k < 8; k++) d[k] = wave[i + B / 2 + (k + 1) * B];
        if (wave[i + B / 2] == 1'b0 && wave[i + B / 2 + 9 * B] == 1'b1) rx_bytes.push_back(d);
        i = i + B / 2 + 9 * B;
      end else begin
        i++;
      end
    end
  endtask

  // Cycle 0 carries the request; an optional extra request is driven at inj_cyc.
  task automatic run_send(input logic [15:0] w, input int inj_cyc, input logic [15:0] inj_w,
                          input int ncyc, input string name);
    int   tx_bad   = -1;
    int   busy_bad = -1;
    int   snt_bad  = -1;
    int   snt_rise = -1;
    int   rises    = 0;
    logic tx_got   = 1'b0;
    logic busy_got = 1'b0;
    logic snt_got  = 1'b0;
    logic prev_snt;
    logic e_busy;
    logic e_snt;
    wave.delete();
    prev_snt = model_snt;
    for (int c = 0; c < ncyc; c++) begin
      bus.snd_cmd = (c == 0) || (c == inj_cyc);
      bus.cmd     = (c == 0) ? w : ((c == inj_cyc) ? inj_w : 16'($urandom));
      @(negedge clk);
      wave.push_back(bus.TX);
      e_busy = (c >= 1) && (c < LAT);
      e_snt  = (c == 0) ? model_snt : (c >= LAT);
      if (bus.TX !== exp_tx(w, c - 1) && tx_bad < 0) begin
        tx_bad = c;
        tx_got = bus.TX;
      end
      if (bus.tx_busy !== e_busy && busy_bad < 0) begin
        busy_bad = c;
        busy_got = bus.tx_busy;
      end
      if (bus.cmd_snt !== e_snt && snt_bad < 0) begin
        snt_bad = c;
        snt_got = bus.cmd_snt;
      end
      if (c >= 1 && bus.cmd_snt === 1'b1 && prev_snt === 1'b0) begin
        rises++;
        if (snt_rise < 0) snt_rise = c;
      end
      prev_snt = bus.cmd_snt;
      @(posedge clk);
      #1;
    end
    bus.snd_cmd = 1'b0;
    model_snt   = (ncyc > LAT);

    checks++;
    if (tx_bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s tx_wave: cycle %0d got TX=%b want %b", name, tx_bad, tx_got,
               exp_tx(w, tx_bad - 1));
    end
    checks++;
    if (busy_bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s tx_busy: cycle %0d got %b want %b", name, busy_bad, busy_got,
               ~busy_got);
    end
    checks++;
    if (snt_bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s cmd_snt: cycle %0d got %b want %b", name, snt_bad, snt_got,
               ~snt_got);
    end
    checks++;
    if (snt_rise != LAT || rises != 1) begin
      errors++;
      $display("[TB] FAIL %s snt_rise: got cycle %0d (%0d rises) want cycle %0d (1 rise)", name,
               snt_rise, rises, LAT);
    end
    decode_wave();
    checks++;
    if (rx_bytes.size() != 2 || rx_bytes[0] !== w[15:8] || rx_bytes[1] !== w[7:0]) begin
      errors++;
      $display("[TB] FAIL %s rx_decode: got %0d bytes first %h second %h want %h %h", name,
               rx_bytes.size(), (rx_bytes.size() > 0) ? rx_bytes[0] : 8'hxx,
               (rx_bytes.size() > 1) ? rx_bytes[1] : 8'hxx, w[15:8], w[7:0]);
    end
  endtask

  task automatic test_reset();
    int         bad = -1;
    logic [2:0] got = 3'b000;
    rst_n       = 1'b0;
    bus.snd_cmd = 1'b0;
    bus.cmd     = '0;
    @(negedge clk);
    checks++;
    if ({bus.TX, bus.cmd_snt, bus.tx_busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_values: got TX/snt/busy=%b want 100",
               {bus.TX, bus.cmd_snt, bus.tx_busy});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ({bus.TX, bus.cmd_snt, bus.tx_busy} !== 3'b100 && bad < 0) begin
        bad = c;
        got = {bus.TX, bus.cmd_snt, bus.tx_busy};
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL reset_idle: cycle %0d got TX/snt/busy=%b want 100", bad, got);
    end
    model_snt = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run_send(16'hA53C, -1, 16'h0000, LAT + 8, "basic_A53C");
  endtask

  task automatic test_loopback();
    run_send(16'h00F3, -1, 16'h0000, LAT + 8, "loopback_00F3");
  endtask

  task automatic test_ignore_busy();
    run_send(16'h9C81, 100, 16'h1234, LAT + 8, "ignore_busy");
  endtask

  task automatic test_done_boundary();
    run_send(16'h6E17, LAT - 1, 16'hBEEF, LAT + 3 * B, "done_boundary");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) run_send(16'($urandom), -1, 16'h0000, LAT + 2, "random");
  endtask

  task automatic test_reset_mid();
    int rc;
    rc = 1 + 10 * B + GAP_CLKS + 4 * B;
    for (int c = 0; c < rc; c++) begin
      bus.snd_cmd = (c == 0);
      bus.cmd     = 16'hC300;
      @(posedge clk);
      #1;
    end
    bus.snd_cmd = 1'b0;
    checks++;
    if (bus.TX !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pre_reset_tx: got TX=%b want 0", bus.TX);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.TX, bus.cmd_snt, bus.tx_busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL reset_mid: got TX/snt/busy=%b want 100",
               {bus.TX, bus.cmd_snt, bus.tx_busy});
    end
    model_snt = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_send(16'h5A5A, -1, 16'h0000, LAT + 8, "after_reset_5A5A");
  endtask

`ifdef CMD_TX_GAP_EN
  task automatic test_gap();
    run_send(16'hFFFF, -1, 16'h0000, LAT + 8, "gap_FFFF");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_loopback();
    test_ignore_busy();
    test_done_boundary();
    test_back_to_back();
    test_reset_mid();
`ifdef CMD_TX_GAP_EN
    test_gap();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
